// File: rtl/reg_pipe_pkg.sv
// Shared types and helpers for the elastic register pipeline.
// Holds the slice state encoding and the occupancy-counter width rule.
package reg_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } slice_state_e;

  // Each slice holds up to two words, so count must reach 2*STAGES inclusive.
  function automatic int count_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/reg_slice.sv
// One skid-buffer slice: a main and a skid register with valid/ready on both sides.
// in_ready comes from a flop, so there is no combinational out_ready -> in_ready path.
module reg_slice
  import reg_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  slice_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q;
  logic             in_xfer;
  logic             out_xfer;

  // Flush blocks new words in the same cycle it discards held ones.
  assign in_ready  = ready_q & ~flush;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else if (flush) begin
      // Data registers keep their contents; only the valid state is discarded.
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != FULL);
    end
  end

endmodule

// File: rtl/reg_pipe.sv
// Elastic register pipeline: STAGES chained skid slices plus an occupancy counter.
// Capacity is 2*STAGES words; order is preserved end to end.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [count_width(STAGES)-1:0]   count
);

  localparam int CW = count_width(STAGES);

  logic [WIDTH-1:0] s_data  [STAGES+1];
  logic             s_valid [STAGES+1];
  logic             s_ready [STAGES+1];
  logic [CW-1:0]    count_q, count_d;
  logic             in_xfer;
  logic             out_xfer;

  assign s_data[0]      = in_data;
  assign s_valid[0]     = in_valid;
  assign in_ready       = s_ready[0];
  assign out_data       = s_data[STAGES];
  assign out_valid      = s_valid[STAGES];
  assign s_ready[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    reg_slice #(.WIDTH(WIDTH)) u_slice (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_data   (s_data[k]),
      .in_valid  (s_valid[k]),
      .in_ready  (s_ready[k]),
      .out_data  (s_data[k+1]),
      .out_valid (s_valid[k+1]),
      .out_ready (s_ready[k+1])
    );
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    case ({in_xfer, out_xfer})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
